// File: rtl/irq_vector_controller_if.sv
// CPU-side register bus of the interrupt controller: 8-bit data, 2-bit register select.
interface irq_vector_controller_if;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic       cs;
    logic       rwb;
    logic [1:0] addr;

    modport master (output i_data, cs, rwb, addr, input o_data);
    modport slave  (input i_data, cs, rwb, addr, output o_data);
endinterface

// File: rtl/irq_vector_controller.sv
// Aggregates active-low requests into a registered IRQB with priority vector readback.
// Latency: SYNC_STAGES+1 clocks (level) / +2 (edge) to irqb_master; no backpressure, reads are combinational.
module irq_vector_controller #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    irq_vector_controller_if.slave bus,
    input  logic [NUM_SRC-1:0]  irqb_in,
    output logic                irqb_master
);

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] mode_q;
    logic [NUM_SRC-1:0] edge_latch_q;

    logic [NUM_SRC-1:0] synced;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] fall;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] wr_val;
    logic [NUM_SRC-1:0] mode_nxt;
    logic [NUM_SRC-1:0] w1c;
    logic               wr;
    logic [7:0]         pending8;
    logic [7:0]         enable8;
    logic [7:0]         mode8;
    logic [2:0]         vec_idx;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign req     = ~synced;
    assign fall    = prev_q & ~synced;
    assign pending = (mode_q & edge_latch_q) | (~mode_q & req);
    assign active  = pending & enable_q;

    assign wr       = bus.cs & ~bus.rwb;
    assign wr_val   = bus.i_data[NUM_SRC-1:0];
    assign mode_nxt = (wr && bus.addr == 2'd2) ? wr_val : mode_q;
    assign w1c      = (wr && bus.addr == 2'd3) ? wr_val : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
            prev_q       <= '1;
            enable_q     <= '0;
            mode_q       <= '0;
            edge_latch_q <= '0;
            irqb_master  <= 1'b1;
        end else begin
            sync_q[0] <= irqb_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= synced;
            if (wr && bus.addr == 2'd1) enable_q <= wr_val;
            mode_q <= mode_nxt;
            // New falls beat a same-cycle W1C; leaving edge mode drops the latch.
            edge_latch_q <= ((edge_latch_q & ~w1c) | (fall & mode_q)) & mode_nxt;
            irqb_master  <= ~|active;
        end
    end

    always_comb begin
        pending8 = '0;
        enable8  = '0;
        mode8    = '0;
        pending8[NUM_SRC-1:0] = pending;
        enable8[NUM_SRC-1:0]  = enable_q;
        mode8[NUM_SRC-1:0]    = mode_q;
    end

    always_comb begin
        vec_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) vec_idx = 3'(i);
        end
    end

    always_comb begin
        bus.o_data = '0;
        case (bus.addr)
            2'd0:    bus.o_data = pending8;
            2'd1:    bus.o_data = enable8;
            2'd2:    bus.o_data = mode8;
            default: bus.o_data = {~|active, 4'b0000, vec_idx};
        endcase
    end

endmodule

// File: tb/tb_irq_vector_controller.sv
// Directed bench for irq_vector_controller: expected values queued at stimulus time, popped at sample time.
module tb_irq_vector_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irqb_in;
    logic       irqb_master;

    irq_vector_controller_if bus();

    irq_vector_controller #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .irqb_in     (irqb_in),
        .irqb_master (irqb_master)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_val(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        bus.addr = a;
        #1;
        d = bus.o_data;
    endtask

    task automatic expect_reg(input string tag, input logic [1:0] a, input logic [7:0] val);
        logic [7:0] d;
        expect_val(tag, val);
        rd(a, d);
        check(d);
    endtask

    task automatic expect_irqb(input string tag, input logic val);
        expect_val(tag, {7'd0, val});
        check({7'd0, irqb_master});
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.cs     = 1'b1;
        bus.rwb    = 1'b0;
        bus.addr   = a;
        bus.i_data = d;
        tick();
        bus.cs     = 1'b0;
        bus.rwb    = 1'b1;
        bus.i_data = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        irqb_in    = 8'hFF;
        bus.cs     = 1'b0;
        bus.rwb    = 1'b1;
        bus.addr   = 2'd0;
        bus.i_data = 8'h00;

        // Reset state
        tick(2);
        expect_irqb("rst_irqb_held", 1'b1);
        expect_reg("rst_status", 2'd0, 8'h00);
        expect_reg("rst_enable", 2'd1, 8'h00);
        expect_reg("rst_mode",   2'd2, 8'h00);
        expect_reg("rst_vector", 2'd3, 8'h80);
        reset = 1'b0;
        tick();
        expect_irqb("post_rst_irqb", 1'b1);
        expect_reg("post_rst_vector", 2'd3, 8'h80);

        // Level mode latency
        wr(2'd1, 8'h01);
        irqb_in = 8'hFE;
        tick(2);
        expect_irqb("lvl_irqb_t2", 1'b1);
        tick();
        expect_irqb("lvl_irqb_t3", 1'b0);
        expect_reg("lvl_vector", 2'd3, 8'h00);
        expect_reg("lvl_status", 2'd0, 8'h01);
        irqb_in = 8'hFF;
        tick(2);
        expect_irqb("lvl_rel_t2", 1'b0);
        tick();
        expect_irqb("lvl_rel_t3", 1'b1);

        // Priority
        wr(2'd1, 8'hFF);
        irqb_in = 8'b1101_1011;
        tick(3);
        expect_reg("prio_vec_2", 2'd3, 8'h02);
        irqb_in = 8'b1101_1111;
        tick(3);
        expect_reg("prio_vec_5", 2'd3, 8'h05);
        irqb_in = 8'hFF;
        tick(3);
        expect_reg("prio_vec_none", 2'd3, 8'h80);
        expect_irqb("prio_irqb_idle", 1'b1);

        // Edge mode: one-clock pulse latched
        wr(2'd2, 8'h08);
        wr(2'd1, 8'h08);
        irqb_in = 8'hF7;
        tick();
        irqb_in = 8'hFF;
        tick(2);
        expect_irqb("edge_irqb_t3", 1'b1);
        tick();
        expect_irqb("edge_irqb_t4", 1'b0);
        tick(3);
        expect_irqb("edge_irqb_held", 1'b0);
        expect_reg("edge_status", 2'd0, 8'h08);
        expect_reg("edge_vector", 2'd3, 8'h03);
        wr(2'd3, 8'h08);
        expect_reg("edge_w1c_status", 2'd0, 8'h00);
        tick();
        expect_irqb("edge_w1c_irqb", 1'b1);

        // Masked edge remembered, then enabled
        wr(2'd2, 8'h10);
        wr(2'd1, 8'h00);
        irqb_in = 8'hEF;
        tick();
        irqb_in = 8'hFF;
        tick(5);
        expect_irqb("mask_irqb", 1'b1);
        expect_reg("mask_status", 2'd0, 8'h10);
        expect_reg("mask_vector", 2'd3, 8'h80);
        wr(2'd1, 8'h10);
        expect_irqb("mask_en_t1", 1'b1);
        tick();
        expect_irqb("mask_en_t2", 1'b0);
        // Leaving edge mode drops the latch in the same write
        wr(2'd2, 8'h00);
        expect_reg("mode_clr_status", 2'd0, 8'h00);
        tick();
        expect_irqb("mode_clr_irqb", 1'b1);

        // Collision of fall and W1C, then reset mid-interrupt
        wr(2'd2, 8'h02);
        wr(2'd1, 8'h02);
        irqb_in = 8'hFD;
        tick(2);
        wr(2'd3, 8'h02);
        expect_reg("coll_status", 2'd0, 8'h02);
        tick();
        expect_irqb("coll_irqb", 1'b0);
        reset = 1'b1;
        tick();
        expect_irqb("midrst_irqb_t1", 1'b1);
        expect_reg("midrst_enable", 2'd1, 8'h00);
        expect_reg("midrst_mode",   2'd2, 8'h00);
        expect_reg("midrst_status", 2'd0, 8'h00);
        expect_reg("midrst_vector", 2'd3, 8'h80);
        tick();
        expect_irqb("midrst_irqb_t2", 1'b1);
        reset = 1'b0;
        tick(4);
        expect_irqb("after_rst_irqb", 1'b1);
        expect_reg("after_rst_enable", 2'd1, 8'h00);
        expect_reg("after_rst_status", 2'd0, 8'h02);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
